md_sched: RTL and testbench

- Multiply/divide scheduler for the E stage of the 5-stage pipeline. Sequences mult/multu/div/divu over a fixed latency and owns the HI/LO registers.
- Executes mthi/mtlo writes and supplies mfhi/mflo read data.
- Drives the busy flag that the stall logic combines with the D-stage "uses md unit" flag to hold md instructions in D.
- Honours the exception/interrupt request so a flushed E-stage instruction never starts or writes HI/LO.

---
 rtl/md_sched.sv | 178 +++++++++++++++++
 tb/tb_md_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, computes the result at start
// and commits it to HI/LO after a fixed busy window; mthi/mtlo write immediately.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   res_hi_r, res_hi_s;
  logic [31:0]   res_lo_r, res_lo_s;
  logic          dz_r, dz_s;
  logic [31:0]   hi_r, hi_s;
  logic [31:0]   lo_r, lo_s;

  op_e           op_s;
  logic          is_md_s;
  logic          is_signed_s;
  logic          accept_s;
  logic [63:0]   mul_a_s;
  logic [63:0]   mul_b_s;
  logic [63:0]   prod_s;
  logic          a_neg_s;
  logic          b_neg_s;
  logic          div_zero_s;
  logic [31:0]   div_a_s;
  logic [31:0]   div_b_s;
  logic [31:0]   div_d_s;
  logic [31:0]   uq_s;
  logic [31:0]   ur_s;
  logic [31:0]   quo_s;
  logic [31:0]   rem_s;

  assign op_s        = op_e'(op);
  assign is_md_s     = (op_s == OP_MULT) || (op_s == OP_MULTU) ||
                       (op_s == OP_DIV)  || (op_s == OP_DIVU);
  assign is_signed_s = (op_s == OP_MULT) || (op_s == OP_DIV);
  assign accept_s    = ~req & (cnt_r == CNT_ZERO) & is_md_s;
  assign busy        = accept_s | (cnt_r != CNT_ZERO);

  // One 64-bit multiplier serves both signednesses via operand extension.
  assign mul_a_s = {{32{A[31] & is_signed_s}}, A};
  assign mul_b_s = {{32{B[31] & is_signed_s}}, B};
  assign prod_s  = mul_a_s * mul_b_s;

  // Signed divide runs on magnitudes; 0x80000000 negates to itself, which is the
  // correct unsigned magnitude, so MIN/-1 yields 0x80000000 with no special case.
  assign a_neg_s    = is_signed_s & A[31];
  assign b_neg_s    = is_signed_s & B[31];
  assign div_zero_s = (B == 32'd0);
  assign div_a_s    = a_neg_s ? (32'd0 - A) : A;
  assign div_b_s    = b_neg_s ? (32'd0 - B) : B;
  assign div_d_s    = div_zero_s ? 32'd1 : div_b_s;
  assign uq_s       = div_a_s / div_d_s;
  assign ur_s       = div_a_s % div_d_s;
  assign quo_s      = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
  assign rem_s      = a_neg_s ? (32'd0 - ur_s) : ur_s;

  // Next-state logic: start/mt* in IDLE, countdown and commit in RUN.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    res_hi_s = res_hi_r;
    res_lo_s = res_lo_r;
    dz_s     = dz_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    case (state_r)
      IDLE: begin
        if (!req) begin
          case (op_s)
            OP_MULT, OP_MULTU: begin
              state_s  = RUN;
              cnt_s    = MULT_CNT;
              res_hi_s = prod_s[63:32];
              res_lo_s = prod_s[31:0];
              dz_s     = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_s  = RUN;
              cnt_s    = DIV_CNT;
              res_hi_s = rem_s;
              res_lo_s = quo_s;
              dz_s     = div_zero_s;
            end
            OP_MTHI: hi_s = A;
            OP_MTLO: lo_s = A;
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ONE) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          if (!dz_r) begin
            hi_s = res_hi_r;
            lo_s = res_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      res_hi_r <= 32'd0;
      res_lo_r <= 32'd0;
      dz_r     <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      res_hi_r <= res_hi_s;
      res_lo_r <= res_lo_s;
      dz_r     <= dz_s;
      hi_r     <= hi_s;
      lo_r     <= lo_s;
    end
  end

  assign HI      = hi_r;
  assign LO      = lo_r;
  assign rd_data = rd_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus queues expected completions and probes,
// a negedge monitor pops and compares them.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        rd_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } cmp_t;

  typedef struct {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
  } probe_t;

  cmp_t   cmp_q[$];
  probe_t probe_q[$];
  logic   probe_en = 1'b0;
  logic   mon_en   = 1'b0;
  int     checks   = 0;
  int     errors   = 0;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op(op), .A(a), .B(b), .req(req), .rd_hi(rd_hi),
    .busy(busy), .HI(hi), .LO(lo), .rd_data(rd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    probe_en = 1'b0;
  endtask

  task automatic probe(input logic eb, input logic [31:0] eh, input logic [31:0] el,
                       input logic [31:0] er);
    probe_q.push_back(probe_t'{eb, eh, el, er});
    probe_en = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input int len, input logic [31:0] eh, input logic [31:0] el);
    cmp_q.push_back(cmp_t'{len, eh, el});
    op = o; a = va; b = vb; req = 1'b0; rd_hi = 1'b0;
    tick();
    op = 3'd0;
    wait_idle();
    tick();
  endtask

  // Monitor: probes, busy-window completions and the no-md-op-while-running rule.
  initial begin
    logic   prev_busy;
    int     run_len;
    cmp_t   c;
    probe_t p;
    prev_busy = 1'b0;
    run_len   = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (probe_en) begin
          if (probe_q.size() == 0) begin
            chk("probe_underflow", 32'd1, 32'd0);
          end else begin
            p = probe_q.pop_front();
            chk("probe_busy", {31'd0, busy}, {31'd0, p.busy});
            chk("probe_hi", hi, p.hi);
            chk("probe_lo", lo, p.lo);
            chk("probe_rd_data", rd_data, p.rd);
          end
        end
        if (busy === 1'b1 && prev_busy) begin
          chk("md_op_while_busy", {31'd0, (!req && op >= 3'd1 && op <= 3'd6)}, 32'd0);
        end
        if (busy === 1'b1) begin
          run_len++;
        end else if (prev_busy) begin
          if (cmp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            c = cmp_q.pop_front();
            chk("busy_len", run_len, c.len);
            chk("result_hi", hi, c.hi);
            chk("result_lo", lo, c.lo);
          end
          run_len = 0;
        end
        prev_busy = (busy === 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op = 3'd0; a = 32'd0; b = 32'd0; req = 1'b0; rd_hi = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    mon_en = 1'b1;
    probe(1'b0, 32'h0, 32'h0, 32'h0);
    tick();

    // Multiply: 6 busy cycles; divide: 11 busy cycles.
    issue(3'd1, 32'hFFFFFFFE, 32'h00000003, 6,  32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFF, 32'h00000002, 6,  32'h00000001, 32'hFFFFFFFE);
    issue(3'd3, 32'hFFFFFFF9, 32'h00000002, 11, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd3, 32'h00000007, 32'hFFFFFFFE, 11, 32'h00000001, 32'hFFFFFFFD);
    issue(3'd4, 32'hFFFFFFFF, 32'h00000010, 11, 32'h0000000F, 32'h0FFFFFFF);
    issue(3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 6,  32'hFFFFFFFF, 32'h80000001);

    // mthi/mtlo: old value readable in the write cycle, no busy.
    op = 3'd5; a = 32'h11; rd_hi = 1'b1;
    probe(1'b0, 32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFF);
    tick();
    op = 3'd6; a = 32'h22; rd_hi = 1'b0;
    probe(1'b0, 32'h00000011, 32'h80000001, 32'h80000001);
    tick();
    op = 3'd0; rd_hi = 1'b1;
    probe(1'b0, 32'h00000011, 32'h00000022, 32'h00000011);
    tick();

    issue(3'd4, 32'd100, 32'd0, 11, 32'h00000011, 32'h00000022);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 11, 32'h00000000, 32'h80000000);

    // Flushed mult must neither start nor assert busy.
    op = 3'd1; a = 32'd5; b = 32'd5; req = 1'b1; rd_hi = 1'b0;
    probe(1'b0, 32'h0, 32'h80000000, 32'h80000000);
    tick();
    op = 3'd0; req = 1'b0;
    probe(1'b0, 32'h0, 32'h80000000, 32'h80000000);
    tick();
    op = 3'd6; a = 32'h1234;
    probe(1'b0, 32'h0, 32'h80000000, 32'h80000000);
    tick();
    op = 3'd0;
    probe(1'b0, 32'h0, 32'h00001234, 32'h00001234);
    tick();

    // Reset on the 4th RUN edge of a divide: 5 busy cycles, result dropped.
    cmp_q.push_back(cmp_t'{5, 32'h0, 32'h0});
    op = 3'd3; a = 32'd20; b = 32'd3;
    tick();
    op = 3'd0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    rd_hi = 1'b1;
    probe(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();

    chk("cmp_queue_empty", cmp_q.size(), 32'd0);
    chk("probe_queue_empty", probe_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
